// File: rtl/multi_button_ctrl.sv
// Debounced multi-button front end: one enable pulse per accepted press.
// Define AUTOREPEAT_EN to add hold-to-repeat pulses while the button stays down.
module multi_button_ctrl #(
   parameter int                 NUM_BTN         = 2,
   parameter int                 DEBOUNCE_CYCLES = 4,
   parameter logic [NUM_BTN-1:0] UP_MASK         = NUM_BTN'(2'b10),
   parameter int                 REPEAT_DELAY    = 16,
   parameter int                 REPEAT_PERIOD   = 8,
   localparam int                IDX_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] button_n,
   output logic               enable,
   output logic               up_down,
   output logic [IDX_W-1:0]   btn_idx,
   output logic               busy
);

   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] REL_END = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (NUM_BTN < 2 || DEBOUNCE_CYCLES < 1 ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("multi_button_ctrl: illegal parameter value");
   end

   typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

   state_t             state, state_nx;
   logic [NUM_BTN-1:0] meta, sync;
   logic [IDX_W-1:0]   cand, cand_nx, low_idx, idx_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx, rel_cnt, rel_nx;
   logic               enable_nx, up_down_nx;
   logic               any_low, all_high;

`ifdef AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                            REPEAT_DELAY : REPEAT_PERIOD;
   localparam int               REP_W   = $clog2(REP_MAX + 1);
   localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] REP_PER = REP_W'(REPEAT_PERIOD - 1);

   logic [REP_W-1:0] rep_cnt, rep_nx;
   logic             rep_first, first_nx;
   logic             rep_stop, stop_nx;
`endif

   assign any_low  = ~&sync;
   assign all_high = &sync;
   assign busy     = (state != IDLE);

   always_comb begin
      low_idx = '0;
      for (int i = NUM_BTN - 1; i >= 0; i--)
         if (!sync[i]) low_idx = IDX_W'(i);
   end

   always_comb begin
      state_nx   = state;
      cand_nx    = cand;
      cnt_nx     = cnt;
      rel_nx     = rel_cnt;
      enable_nx  = 1'b0;
      up_down_nx = 1'b0;
      idx_nx     = btn_idx;
`ifdef AUTOREPEAT_EN
      rep_nx     = rep_cnt;
      first_nx   = rep_first;
      stop_nx    = rep_stop;
`endif
      unique case (state)
         IDLE: begin
            if (any_low) begin
               cand_nx  = low_idx;
               cnt_nx   = CNT_W'(1);
               state_nx = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (sync[cand]) begin
               cnt_nx   = '0;
               state_nx = IDLE;
            end else if (cnt == CNT_MAX) begin
               cnt_nx     = '0;
               rel_nx     = '0;
               state_nx   = HELD;
               enable_nx  = 1'b1;
               up_down_nx = UP_MASK[cand];
               idx_nx     = cand;
`ifdef AUTOREPEAT_EN
               rep_nx     = '0;
               first_nx   = 1'b1;
               stop_nx    = 1'b0;
`endif
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         HELD: begin
            if (!all_high) begin
               rel_nx = '0;
            end else if (rel_cnt == REL_END) begin
               rel_nx   = '0;
               state_nx = IDLE;
            end else begin
               rel_nx = rel_cnt + CNT_W'(1);
            end
`ifdef AUTOREPEAT_EN
            // once the candidate lifts, repeats stay off until HELD is left
            if (!rep_stop) begin
               if (sync[cand]) begin
                  stop_nx = 1'b1;
                  rep_nx  = '0;
               end else if (rep_cnt == (rep_first ? REP_DLY : REP_PER)) begin
                  enable_nx  = 1'b1;
                  up_down_nx = UP_MASK[cand];
                  idx_nx     = cand;
                  rep_nx     = '0;
                  first_nx   = 1'b0;
               end else begin
                  rep_nx = rep_cnt + REP_W'(1);
               end
            end
`endif
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta      <= '1;
         sync      <= '1;
         state     <= IDLE;
         cand      <= '0;
         cnt       <= '0;
         rel_cnt   <= '0;
         enable    <= 1'b0;
         up_down   <= 1'b0;
         btn_idx   <= '0;
`ifdef AUTOREPEAT_EN
         rep_cnt   <= '0;
         rep_first <= 1'b0;
         rep_stop  <= 1'b0;
`endif
      end else begin
         meta      <= button_n;
         sync      <= meta;
         state     <= state_nx;
         cand      <= cand_nx;
         cnt       <= cnt_nx;
         rel_cnt   <= rel_nx;
         enable    <= enable_nx;
         up_down   <= up_down_nx;
         btn_idx   <= idx_nx;
`ifdef AUTOREPEAT_EN
         rep_cnt   <= rep_nx;
         rep_first <= first_nx;
         rep_stop  <= stop_nx;
`endif
      end
   end

endmodule

// File: tb/tb_multi_button_ctrl.sv
// Bench for multi_button_ctrl: directed scenarios plus random pressing,
// checked every cycle against a rule-level model of the button front end.
module tb_multi_button_ctrl;

   localparam int D  = 4;
   localparam int RD = 16;
   localparam int RP = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] bn2 = 2'b00;
   logic [3:0] bn4 = 4'h0;
   logic       en2, ud2, busy2;
   logic [0:0] idx2;
   logic       en4, ud4, busy4;
   logic [1:0] idx4;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   multi_button_ctrl #(
      .NUM_BTN(2), .DEBOUNCE_CYCLES(D), .UP_MASK(2'b10),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut2 (
      .clk(clk), .reset(reset), .button_n(bn2), .enable(en2),
      .up_down(ud2), .btn_idx(idx2), .busy(busy2)
   );

   multi_button_ctrl #(
      .NUM_BTN(4), .DEBOUNCE_CYCLES(D), .UP_MASK(4'b0101),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut4 (
      .clk(clk), .reset(reset), .button_n(bn4), .enable(en4),
      .up_down(ud4), .btn_idx(idx4), .busy(busy4)
   );

   // Reference model: synced view is the raw input two edges old; a press
   // is accepted once its channel stays low through D+1 synced samples.
   logic [3:0] m_s1[2], m_s2[2];
   logic       m_trk[2], m_lck[2], m_rdead[2];
   int         m_cand[2], m_low[2], m_rel[2], m_hold[2];
   logic       e_en[2], e_ud[2];
   int         e_idx[2];
   int         mp2[$], mp4[$];
   int         pc2[$], pc4[$];
   int         busy_seen2 = 0;

   function automatic int lowest(input logic [3:0] s);
      int r;
      r = 0;
      for (int i = 3; i >= 0; i--)
         if (!s[i]) r = i;
      return r;
   endfunction

   task automatic fire(input int k, input logic [3:0] mask);
      e_en[k]  = 1'b1;
      e_ud[k]  = mask[m_cand[k]];
      e_idx[k] = m_cand[k];
      if (k == 0) mp2.push_back(cyc);
      else mp4.push_back(cyc);
   endtask

   task automatic step(input int k, input logic rst,
                       input logic [3:0] raw, input logic [3:0] mask);
      logic [3:0] s;
      s = m_s2[k];
      if (rst) begin
         m_s1[k]  = 4'hF;
         m_s2[k]  = 4'hF;
         m_trk[k] = 1'b0;
         m_lck[k] = 1'b0;
         e_en[k]  = 1'b0;
         e_ud[k]  = 1'b0;
         e_idx[k] = 0;
      end else begin
         e_en[k] = 1'b0;
         e_ud[k] = 1'b0;
         if (m_lck[k]) begin
            if (s == 4'hF) begin
               m_rel[k]++;
               if (m_rel[k] == D) m_lck[k] = 1'b0;
            end else begin
               m_rel[k] = 0;
            end
`ifdef AUTOREPEAT_EN
            if (!m_rdead[k]) begin
               if (s[m_cand[k]]) begin
                  m_rdead[k] = 1'b1;
               end else begin
                  m_hold[k]++;
                  if (m_hold[k] == RD ||
                      (m_hold[k] > RD && (m_hold[k] - RD) % RP == 0))
                     fire(k, mask);
               end
            end
`endif
         end else if (m_trk[k]) begin
            if (s[m_cand[k]]) begin
               m_trk[k] = 1'b0;
            end else if (m_low[k] == D) begin
               m_trk[k]   = 1'b0;
               m_lck[k]   = 1'b1;
               m_rel[k]   = 0;
               m_hold[k]  = 0;
               m_rdead[k] = 1'b0;
               fire(k, mask);
            end else begin
               m_low[k]++;
            end
         end else if (s != 4'hF) begin
            m_cand[k] = lowest(s);
            m_low[k]  = 1;
            m_trk[k]  = 1'b1;
         end
         m_s2[k] = m_s1[k];
         m_s1[k] = raw;
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      step(0, reset, {2'b11, bn2}, 4'b0010);
      step(1, reset, bn4, 4'b0101);
   end

   task automatic cmp(input string nm, input logic en, input logic ud,
                      input int idx, input logic bsy, input int k);
      logic eb;
      eb = m_trk[k] | m_lck[k];
      n_chk++;
      if (en === e_en[k] && ud === e_ud[k] && idx == e_idx[k] && bsy === eb)
         n_pass++;
      else
         $display("FAIL %s cyc %0d: got en=%b ud=%b idx=%0d busy=%b expected en=%b ud=%b idx=%0d busy=%b",
                  nm, cyc, en, ud, idx, bsy, e_en[k], e_ud[k], e_idx[k], eb);
   endtask

   always @(negedge clk) begin
      if (cyc >= 1) begin
         cmp("model_dut2", en2, ud2, int'(idx2), busy2, 0);
         cmp("model_dut4", en4, ud4, int'(idx4), busy4, 1);
      end
      if (en2) pc2.push_back(cyc);
      if (en4) pc4.push_back(cyc);
      if (busy2) busy_seen2++;
   end

   task automatic chk(input string nm, input int act, input int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, req);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      pc2.delete();
      pc4.delete();
      mp2.delete();
      mp4.delete();
      busy_seen2 = 0;
   endtask

   int c0;
   int rep_q[$];
   int ref_off[4];

   initial begin
      // reset with both buttons held low
      @(negedge clk);
      chk("t1_rst_en", int'(en2), 0);
      chk("t1_rst_busy", int'(busy2), 0);
      chk("t1_rst_idx", int'(idx2), 0);
      @(negedge clk);
      chk("t1_rst2_en", int'(en2), 0);
      chk("t1_rst2_busy4", int'(busy4), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("t1_after_en", int'(en2), 0);
      chk("t1_after_busy", int'(busy2), 0);
      chk("t1_after_idx", int'(idx2), 0);
      tick(1);
      bn2 = 2'b11;
      bn4 = 4'hF;
      tick(15);

      // clean press of ch0
      clear_log();
      bn2 = 2'b10;
      c0 = cyc;
      tick(20);
      chk("t2_pulses", pc2.size(), 1);
      if (pc2.size() > 0) chk("t2_latency", pc2[0] - c0, 7);
      if (mp2.size() > 0) chk("t2_model_latency", mp2[0] - c0, 7);
      chk("t2_idx", int'(idx2), 0);
      bn2 = 2'b11;
      tick(4);
      chk("t2_busy_pre", int'(busy2), 1);
      tick(1);
      chk("t2_busy_post", int'(busy2), 1);
      tick(1);
      chk("t2_busy_idle", int'(busy2), 0);
      tick(10);

      // bouncing ch1
      clear_log();
      for (int r = 0; r < 5; r++) begin
         bn2 = 2'b01;
         tick(3);
         bn2 = 2'b11;
         tick(3);
      end
      tick(8);
      chk("t3_pulses", pc2.size(), 0);
      chk("t3_busy_seen", int'(busy_seen2 > 0), 1);
      chk("t3_busy_end", int'(busy2), 0);

      // simultaneous press, then ch1 held alone
      clear_log();
      bn2 = 2'b00;
      c0 = cyc;
      tick(12);
      bn2 = 2'b01;
      tick(15);
      chk("t4_busy_locked", int'(busy2), 1);
      bn2 = 2'b11;
      tick(12);
      chk("t4_pulses", pc2.size(), 1);
      if (pc2.size() > 0) chk("t4_latency", pc2[0] - c0, 7);
      chk("t4_idx", int'(idx2), 0);
      chk("t4_busy_end", int'(busy2), 0);

      // direction: ch1 on 2-channel, ch2 on 4-channel
      clear_log();
      bn2 = 2'b01;
      bn4 = 4'b1011;
      c0 = cyc;
      tick(6);
      chk("t5_en2_early", int'(en2), 0);
      tick(1);
      chk("t5_en2", int'(en2), 1);
      chk("t5_idx2", int'(idx2), 1);
      chk("t5_ud2", int'(ud2), 1);
      chk("t5_en4", int'(en4), 1);
      chk("t5_idx4", int'(idx4), 2);
      chk("t5_ud4", int'(ud4), 1);
      tick(1);
      chk("t5_en2_single", int'(en2), 0);
      bn2 = 2'b11;
      bn4 = 4'hF;
      tick(12);

      // long hold of ch1
      clear_log();
      bn2 = 2'b01;
      c0 = cyc;
      tick(40);
`ifdef AUTOREPEAT_EN
      ref_off = '{7, 23, 31, 39};
      chk("t6_pulses", pc2.size(), 4);
      chk("t6_model_pulses", mp2.size(), 4);
`else
      ref_off = '{7, 0, 0, 0};
      chk("t6_pulses", pc2.size(), 1);
      chk("t6_model_pulses", mp2.size(), 1);
`endif
      rep_q = pc2;
      foreach (rep_q[i])
         if (i < 4) chk($sformatf("t6_pulse%0d_off", i), rep_q[i] - c0, ref_off[i]);
      bn2 = 2'b11;
      tick(12);

      // reset mid-hold: fresh debounce needed
      clear_log();
      bn2 = 2'b01;
      c0 = cyc;
      tick(16);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("t6r_busy_reset", int'(busy2), 0);
      chk("t6r_en_reset", int'(en2), 0);
      tick(13);
      chk("t6r_pulses", pc2.size(), 2);
      if (pc2.size() > 1) chk("t6r_second_off", pc2[1] - c0, 24);
      if (mp2.size() > 1) chk("t6r_model_second_off", mp2[1] - c0, 24);
      bn2 = 2'b11;
      tick(12);

      // random pressing with occasional reset
      begin
         int h2, h4;
         h2 = 0;
         h4 = 0;
         for (int c = 0; c < 1500; c++) begin
            if (h2 == 0) begin
               bn2 = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
               h2 = $urandom_range(1, 14);
            end else begin
               h2--;
            end
            if (h4 == 0) begin
               bn4 = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
               h4 = $urandom_range(1, 30);
            end else begin
               h4--;
            end
            reset = ($urandom_range(0, 249) == 0);
            tick(1);
         end
      end
      reset = 1'b0;
      bn2 = 2'b11;
      bn4 = 4'hF;
      tick(40);
      chk("end_busy2", int'(busy2), 0);
      chk("end_busy4", int'(busy4), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
